// File: rtl/round_sat_stream.sv
// round_sat_stream: NCH-channel rounding/saturation stage, wide samples in,
// WIDTH_OUT-bit samples out, two register stages on a valid/ready stream.
// Stage 1 sign/zero-extends, shifts and decides the rounding increment.
// Stage 2 adds the increment, clamps the result, and drives m_*.
module round_sat_stream #(
  parameter int NCH          = 4,
  parameter int WIDTH_IN_MAX = 32,
  parameter int WIDTH_OUT    = 16,
  parameter int CNT_W        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [$clog2(WIDTH_IN_MAX+1)-1:0]    width_in,
  input  logic                                 is_signed,
  input  logic [1:0]                           rnd_mode,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [NCH*WIDTH_IN_MAX-1:0]          s_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [NCH*WIDTH_OUT-1:0]             m_data,
  output logic [NCH-1:0]                       m_sat,
  output logic [NCH-1:0]                       sat_sticky,
  output logic [CNT_W-1:0]                     sat_count,
  input  logic                                 clr_status
);

  localparam int WW = $clog2(WIDTH_IN_MAX + 1);
  localparam int EW = WIDTH_IN_MAX + 1;   // extended value, room for an unsigned full-width sample
  localparam int SW = EW + 1;             // q + inc with one guard bit
  localparam logic [WW-1:0] WMAX = WW'(WIDTH_IN_MAX);
  localparam logic [WW-1:0] WOUT = WW'(WIDTH_OUT);
  localparam logic signed [SW-1:0] SMAX = $signed(SW'((64'sd1 <<< (WIDTH_OUT - 1)) - 64'sd1));
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  localparam logic signed [SW-1:0] UMAX = $signed(SW'((64'sd1 <<< WIDTH_OUT) - 64'sd1));

  typedef struct packed {
    logic signed [EW-1:0] q;
    logic                 inc;
  } s1_t;

  typedef struct packed {
    logic                 sat;
    logic [WIDTH_OUT-1:0] data;
  } s2_t;

  // Extend din[w-1:0], shift right by max(w-WIDTH_OUT,0) and decide the rounding increment.
  function automatic s1_t round_prep(input logic [WIDTH_IN_MAX-1:0] din,
                                     input logic [WW-1:0]           w,
                                     input logic                    sgn,
                                     input logic [1:0]              mode);
    logic [EW-1:0] ext;
    logic [EW-1:0] tmp;
    logic [EW-1:0] low_mask;
    logic [WW-1:0] sh;
    logic          fill;
    logic          g;
    logic          lsb;
    logic          st;
    logic          neg;
    s1_t           r;
    fill = 1'b0;
    for (int i = 0; i < WIDTH_IN_MAX; i++) begin
      if (i + 1 == int'(w)) begin
        fill = sgn & din[i];
      end else begin
        fill = fill;
      end
    end
    for (int i = 0; i < WIDTH_IN_MAX; i++) begin
      if (i < int'(w)) begin
        ext[i] = din[i];
      end else begin
        ext[i] = fill;
      end
    end
    ext[EW-1] = fill;
    if (w > WOUT) begin
      sh = w - WOUT;
    end else begin
      sh = '0;
    end
    // tmp[0] is the guard bit, tmp[1] the result lsb; both zero when nothing is shifted out
    if (sh == '0) begin
      tmp      = '0;
      low_mask = '0;
    end else begin
      tmp      = ext >> (sh - WW'(1));
      low_mask = ~({EW{1'b1}} << (sh - WW'(1)));
    end
    g   = tmp[0];
    lsb = tmp[1];
    st  = |(ext & low_mask);
    neg = ext[EW-1];
    case (mode)
      2'd1:    r.inc = g & (st | ~neg);
      2'd2:    r.inc = 1'b0;
      default: r.inc = g & (st | lsb);
    endcase
    r.q = $signed(ext) >>> sh;
    return r;
  endfunction

  // Add the increment and clamp to the signed or unsigned output range.
  function automatic s2_t round_sat(input s1_t p, input logic sgn);
    logic signed [SW-1:0] sum;
    s2_t                  r;
    sum = $signed({p.q[EW-1], p.q}) + $signed({{(SW-1){1'b0}}, p.inc});
    if (sgn) begin
      if (sum > SMAX) begin
        r.sat  = 1'b1;
        r.data = SMAX[WIDTH_OUT-1:0];
      end else if (sum < SMIN) begin
        r.sat  = 1'b1;
        r.data = SMIN[WIDTH_OUT-1:0];
      end else begin
        r.sat  = 1'b0;
        r.data = sum[WIDTH_OUT-1:0];
      end
    end else begin
      if (sum > UMAX) begin
        r.sat  = 1'b1;
        r.data = UMAX[WIDTH_OUT-1:0];
      end else begin
        r.sat  = 1'b0;
        r.data = sum[WIDTH_OUT-1:0];
      end
    end
    return r;
  endfunction

  logic [WW-1:0]       w_eff;
  logic                s1_valid;
  logic                s1_sgn;
  s1_t [NCH-1:0]       s1_reg;
  s1_t [NCH-1:0]       s1_nxt;
  s2_t [NCH-1:0]       s2_nxt;
  logic                s2_adv;
  logic                out_fire;

  assign s2_adv   = ~m_valid | m_ready;
  assign s_ready  = ~s1_valid | s2_adv;
  assign out_fire = m_valid & m_ready;

  // Per-channel next values for both stages, with the input width clamped to the maximum.
  always_comb begin
    w_eff  = width_in;
    s1_nxt = '0;
    s2_nxt = '0;
    if (width_in > WMAX) begin
      w_eff = WMAX;
    end else begin
      w_eff = width_in;
    end
    for (int k = 0; k < NCH; k++) begin
      s1_nxt[k] = round_prep(s_data[k*WIDTH_IN_MAX +: WIDTH_IN_MAX], w_eff, is_signed, rnd_mode);
      s2_nxt[k] = round_sat(s1_reg[k], s1_sgn);
    end
  end

  // Stage 1: loads whenever it is empty or stage 2 is taking its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sgn   <= 1'b0;
      s1_reg   <= '0;
    end else if (s_ready) begin
      s1_valid <= s_valid;
      if (s_valid) begin
        s1_sgn <= is_signed;
        s1_reg <= s1_nxt;
      end else begin
        s1_sgn <= s1_sgn;
        s1_reg <= s1_reg;
      end
    end else begin
      s1_valid <= s1_valid;
    end
  end

  // Stage 2: output registers; hold steady while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sat   <= '0;
    end else if (s2_adv) begin
      m_valid <= s1_valid;
      if (s1_valid) begin
        for (int k = 0; k < NCH; k++) begin
          m_data[k*WIDTH_OUT +: WIDTH_OUT] <= s2_nxt[k].data;
          m_sat[k]                         <= s2_nxt[k].sat;
        end
      end else begin
        m_data <= m_data;
        m_sat  <= m_sat;
      end
    end else begin
      m_valid <= m_valid;
    end
  end

  // Status: sticky flags and saturating beat counter, clear wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= '0;
      sat_count  <= '0;
    end else if (clr_status) begin
      sat_sticky <= '0;
      sat_count  <= '0;
    end else if (out_fire) begin
      sat_sticky <= sat_sticky | m_sat;
      if ((|m_sat) && (sat_count != {CNT_W{1'b1}})) begin
        sat_count <= sat_count + CNT_W'(1);
      end else begin
        sat_count <= sat_count;
      end
    end else begin
      sat_sticky <= sat_sticky;
      sat_count  <= sat_count;
    end
  end

endmodule

// File: tb/tb_round_sat_stream.sv
// Self-checking bench for round_sat_stream: table-driven vectors through a
// scoreboard queue, plus backpressure and mid-stream reset sequences.
module tb_round_sat_stream;
  localparam int NCH = 4;
  localparam int WI  = 32;
  localparam int WO  = 16;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [5:0]        width_in;
  logic              is_signed;
  logic [1:0]        rnd_mode;
  logic              s_valid;
  logic              s_ready;
  logic [NCH*WI-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [NCH*WO-1:0] m_data;
  logic [NCH-1:0]    m_sat;
  logic [NCH-1:0]    sat_sticky;
  logic [CW-1:0]     sat_count;
  logic              clr_status;

  always #5 clk = ~clk;

  round_sat_stream #(.NCH(NCH), .WIDTH_IN_MAX(WI), .WIDTH_OUT(WO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .width_in(width_in), .is_signed(is_signed),
    .rnd_mode(rnd_mode), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
    .sat_sticky(sat_sticky), .sat_count(sat_count), .clr_status(clr_status)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  sat;
  } exp_t;

  typedef struct {
    int          w;
    bit          sgn;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [15:0] exp_data;
    bit          exp_sat;
  } vec_t;

  exp_t        sbq[$];
  exp_t        pend;
  bit          accepted;
  bit          stall_prev;
  logic [79:0] held;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: integer arithmetic with explicit floor/remainder reasoning.
  function automatic logic [16:0] model(input logic [31:0] din, input int win, input bit sgn,
                                        input logic [1:0] mode);
    int     w, sh;
    longint v, q, rem, half, lo, hi;
    bit     inc, sat;
    w = (win > 32) ? 32 : win;
    if (w == 0) v = 0;
    else begin
      v = longint'({32'd0, din} & ((64'd1 << w) - 64'd1));
      if (sgn && din[w-1]) v = v - (longint'(1) <<< w);
    end
    sh  = (w > 16) ? w - 16 : 0;
    q   = v;
    inc = 1'b0;
    if (sh > 0) begin
      q    = v >>> sh;
      rem  = v - (q <<< sh);
      half = longint'(1) <<< (sh - 1);
      case (mode)
        2'd2:    inc = 1'b0;
        2'd1:    inc = (rem > half) || (rem == half && v >= 0);
        default: inc = (rem > half) || (rem == half && q[0]);
      endcase
    end
    q = q + longint'(inc);
    if (sgn) begin lo = -32768; hi = 32767; end
    else     begin lo = 0;      hi = 65535; end
    sat = 1'b0;
    if (q > hi)      begin q = hi; sat = 1'b1; end
    else if (q < lo) begin q = lo; sat = 1'b1; end
    return {sat, q[15:0]};
  endfunction

  // One cycle: sample at negedge (accept, scoreboard, stall hold), return just after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (rst_n && s_valid && s_ready) begin
      sbq.push_back(pend);
      accepted = 1'b1;
    end
    if (rst_n && stall_prev && m_valid) chk("stall_hold", {12'd0, m_sat, m_data}, held);
    if (rst_n && m_valid && m_ready) begin
      if (sbq.size() == 0) chk("unexpected_beat", 80'(m_data), 80'(0));
      else begin
        e = sbq.pop_front();
        chk("beat_data", 80'(m_data), 80'(e.data));
        chk("beat_sat", 80'(m_sat), 80'(e.sat));
      end
    end
    stall_prev = rst_n && m_valid && !m_ready;
    held       = {12'd0, m_sat, m_data};
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (!accepted && t < 50);
    if (!accepted) chk("accept_timeout", 80'(0), 80'(1));
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk("drain", 80'(sbq.size()), 80'(0));
  endtask

  task automatic drive_same(input vec_t v);
    width_in  = 6'(v.w);
    is_signed = v.sgn;
    rnd_mode  = v.mode;
    s_data    = {NCH{v.din}};
    pend.data = {NCH{v.exp_data}};
    pend.sat  = {NCH{v.exp_sat}};
    s_valid   = 1'b1;
  endtask

  // Distinct per-channel values; expectation from the reference model.
  task automatic drive_mixed(input int b);
    logic [16:0] r;
    logic [31:0] d;
    int          w;
    w         = (b == 5) ? 32 : 25;
    width_in  = 6'(w);
    is_signed = b[0];
    rnd_mode  = 2'(b % 4);
    for (int k = 0; k < NCH; k++) begin
      case (k)
        0:       d = 32'h0000_0100 + 32'(b) * 32'h200;
        1:       d = 32'h01FF_FF00 - 32'(b) * 32'h100;
        2:       d = 32'h00FF_FFFF ^ 32'(b);
        default: d = $urandom;
      endcase
      s_data[k*WI +: WI] = d;
      r = model(d, w, b[0], 2'(b % 4));
      pend.data[k*WO +: WO] = r[15:0];
      pend.sat[k]           = r[16];
    end
    s_valid = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{25, 1'b0, 2'd0, 32'h0000_0100, 16'h0000, 1'b0},
      '{25, 1'b0, 2'd0, 32'h0000_0300, 16'h0002, 1'b0},
      '{25, 1'b0, 2'd0, 32'h0000_0500, 16'h0002, 1'b0},
      '{25, 1'b0, 2'd1, 32'h0000_0100, 16'h0001, 1'b0},
      '{25, 1'b0, 2'd1, 32'h0000_0300, 16'h0002, 1'b0},
      '{25, 1'b0, 2'd1, 32'h0000_0500, 16'h0003, 1'b0},
      '{25, 1'b0, 2'd2, 32'h0000_0100, 16'h0000, 1'b0},
      '{25, 1'b0, 2'd2, 32'h0000_0300, 16'h0001, 1'b0},
      '{25, 1'b0, 2'd2, 32'h0000_0500, 16'h0002, 1'b0},
      '{25, 1'b1, 2'd0, 32'h01FF_FF00, 16'h0000, 1'b0},
      '{25, 1'b1, 2'd1, 32'h01FF_FF00, 16'hFFFF, 1'b0},
      '{25, 1'b1, 2'd2, 32'h01FF_FF00, 16'hFFFF, 1'b0},
      '{25, 1'b1, 2'd3, 32'h01FF_FF00, 16'h0000, 1'b0},
      '{25, 1'b1, 2'd0, 32'h00FF_FFFF, 16'h7FFF, 1'b1},
      '{25, 1'b0, 2'd0, 32'h00FF_FFFF, 16'h8000, 1'b0},
      '{25, 1'b0, 2'd0, 32'h01FF_FFFF, 16'hFFFF, 1'b1},
      '{12, 1'b1, 2'd0, 32'h0000_0800, 16'hF800, 1'b0},
      '{12, 1'b0, 2'd0, 32'h0000_0800, 16'h0800, 1'b0},
      '{25, 1'b0, 2'd1, 32'hFE00_0100, 16'h0001, 1'b0},
      '{40, 1'b1, 2'd0, 32'h8000_0000, 16'h8000, 1'b0},
      '{ 0, 1'b1, 2'd1, 32'hFFFF_FFFF, 16'h0000, 1'b0}
    };
    rst_n = 1'b0; width_in = 6'd25; is_signed = 1'b0; rnd_mode = 2'd0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1; clr_status = 1'b0;
    stall_prev = 1'b0; held = '0; accepted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", 80'(m_valid), 80'(0));
    chk("reset_m_data", 80'(m_data), 80'(0));
    chk("reset_status", {sat_sticky, sat_count}, 80'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_s_ready", 80'(s_ready), 80'(1));
    @(posedge clk);
    #1;

    // Table vectors, back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      drive_same(vecs[i]);
      wait_accept();
    end
    drain();
    chk("sat_count", 80'(sat_count), 80'(2));
    chk("sat_sticky", 80'(sat_sticky), 80'(4'hF));
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clr_status", {sat_sticky, sat_count}, 80'(0));

    // Backpressure: sink stalls while six mixed beats are offered.
    m_ready = 1'b0;
    drive_mixed(0);
    wait_accept();
    drive_mixed(1);
    wait_accept();
    drive_mixed(2);
    for (int c = 0; c < 3; c++) begin
      chk("bp_s_ready_low", 80'(s_ready), 80'(0));
      tick();
      chk("bp_no_accept", 80'(accepted), 80'(0));
    end
    m_ready = 1'b1;
    wait_accept();
    for (int b = 3; b < 6; b++) begin
      drive_mixed(b);
      wait_accept();
    end
    drain();

    // Reset with both stages full.
    m_ready = 1'b0;
    drive_mixed(1);
    wait_accept();
    drive_mixed(2);
    wait_accept();
    chk("full_before_reset", 80'(m_valid & ~s_ready), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_m_valid", 80'(m_valid), 80'(0));
    chk("mid_reset_outputs", {m_sat, m_data}, 80'(0));
    chk("mid_reset_status", {sat_sticky, sat_count}, 80'(0));
    sbq.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_s_ready", 80'(s_ready), 80'(1));
    @(posedge clk);
    #1;
    drive_same(vecs[5]);
    wait_accept();
    @(negedge clk);
    chk("latency_cycle1", 80'(m_valid), 80'(0));
    @(posedge clk);
    #1;
    tick();
    chk("latency_cycle2", 80'(sbq.size()), 80'(0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
